// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: circular buffer holding pc, pc+4, instruction
// word and predictor bit per entry; flush and reset discard everything.
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq_valid,
    input  logic [31:0]      enq_pc,
    input  logic [31:0]      enq_pc_p4,
    input  logic [31:0]      enq_instr,
    input  logic             enq_taken,
    output logic             enq_ready,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [31:0]      deq_pc,
    output logic [31:0]      deq_pc_p4,
    output logic [31:0]      deq_instr,
    output logic             deq_taken,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [31:0] data_t;
    typedef logic [31:0] instr_t;

    localparam instr_t NOP = 32'h0000_0013;

    typedef struct packed {
        data_t  pc;
        data_t  pc_p4;
        instr_t instr;
        logic   taken;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             not_empty;
    logic             push;
    logic             pop;

    // Ready looks only at registered occupancy, so a full queue never accepts
    // an entry on the strength of a simultaneous pop.
    assign enq_ready = (cnt_q != CNT_W'(DEPTH));
    assign not_empty = (cnt_q != '0);
    assign deq_valid = not_empty && !flush;
    assign push      = enq_valid && enq_ready && !flush;
    assign pop       = deq_valid && deq_ready;
    assign count     = cnt_q;
    assign head      = mem[rd_ptr];

    always_comb begin
        deq_pc    = '0;
        deq_pc_p4 = '0;
        deq_instr = NOP;
        deq_taken = 1'b0;
        if (deq_valid) begin
            deq_pc    = head.pc;
            deq_pc_p4 = head.pc_p4;
            deq_instr = head.instr;
            deq_taken = head.taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {enq_pc, enq_pc_p4, enq_instr, enq_taken};
        end
    end

endmodule
